byte_word_loader: RTL and testbench

- Parametrised successor to the UART byte-to-word packer on the programming-load path.
- Assembles bytes from the serial receiver into BYTES_PER_WORD-wide words and presents each word to instruction/data memory with a held write strobe and an auto-incrementing address.
- Adds selectable byte order, partial-word flush with byte mask, a one-byte skid buffer during writes, overrun detection and a committed-word counter.

---
 rtl/byte_word_loader.sv | 166 ++++++++++++++++
 tb/tb_byte_word_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_word_loader.sv
// Byte-to-word loader for the programming-load path.
// Packs received bytes into BYTES_PER_WORD-wide words, presents each word to
// memory with a held write strobe and an auto-incrementing byte address, and
// supports selectable byte order, partial-word flush with byte mask, a one-byte
// skid buffer while a write is in progress, sticky overrun and a word counter.
module byte_word_loader #(
    parameter int                    BYTES_PER_WORD = 4,
    parameter int                    ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = {ADDR_WIDTH{1'b0}},
    parameter int                    WRITE_HOLD     = 16,
    parameter int                    BIG_ENDIAN     = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    DataIn,
    input  logic                          Ready,
    input  logic                          Flush,
    output logic [8*BYTES_PER_WORD-1:0]   DataOut,
    output logic [ADDR_WIDTH-1:0]         Address,
    output logic                          WriteEn,
    output logic [BYTES_PER_WORD-1:0]     ByteMask,
    output logic                          Busy,
    output logic                          Overrun,
    output logic [15:0]                   WordCount
);

    localparam int DW = 8 * BYTES_PER_WORD;
    localparam int CW = $clog2(BYTES_PER_WORD + 1);
    localparam int HW = (WRITE_HOLD > 1) ? $clog2(WRITE_HOLD) : 1;

    localparam logic [0:0] S_FILL  = 1'b0;
    localparam logic [0:0] S_WRITE = 1'b1;

    localparam logic [CW-1:0]         LAST_IDX  = CW'(BYTES_PER_WORD - 1);
    localparam logic [HW-1:0]         HOLD_LAST = HW'(WRITE_HOLD - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BYTES_PER_WORD);

    // Lane that byte k of a word lands in, according to the byte order.
    function automatic int lane_of(input int k);
        if (BIG_ENDIAN != 0) begin
            lane_of = BYTES_PER_WORD - 1 - k;
        end else begin
            lane_of = k;
        end
    endfunction

    // Byte mask covering the first n bytes of a word.
    function automatic logic [BYTES_PER_WORD-1:0] lanes_filled(input logic [CW-1:0] n);
        logic [BYTES_PER_WORD-1:0] m;
        m = {BYTES_PER_WORD{1'b0}};
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (k < int'(n)) begin
                m[lane_of(k)] = 1'b1;
            end else begin
                m[lane_of(k)] = 1'b0;
            end
        end
        return m;
    endfunction

    logic [0:0]    r_state;
    logic [DW-1:0] r_asm;
    logic [CW-1:0] r_cnt;
    logic [HW-1:0] r_hold;
    logic          r_skid_valid;
    logic [7:0]    r_skid_data;

    logic [DW-1:0] w_asm_next;
    logic [DW-1:0] w_first_word;
    logic [CW-1:0] w_cnt_after;
    logic          w_commit;
    logic          w_hold_done;
    logic          w_carry_valid;
    logic [7:0]    w_carry_byte;

    // Next assembly value, commit decision and the first byte of the next word.
    always_comb begin
        w_asm_next = r_asm;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            w_asm_next[lane_of(k)*8 +: 8] = (Ready && (r_cnt == CW'(k)))
                                          ? DataIn
                                          : r_asm[lane_of(k)*8 +: 8];
        end
        w_cnt_after = r_cnt + {{(CW-1){1'b0}}, Ready};

        // A byte accepted together with Flush is part of the flushed word.
        w_commit = (r_state == S_FILL) &&
                   ((Ready && (r_cnt == LAST_IDX)) ||
                    (Flush && (w_cnt_after != {CW{1'b0}})));

        w_hold_done = (r_state == S_WRITE) && (r_hold == HOLD_LAST);

        // A byte arriving on the last hold cycle with an empty skid buffer
        // goes straight into slot 0 of the next word instead of being lost.
        w_carry_valid = r_skid_valid || Ready;
        w_carry_byte  = r_skid_valid ? r_skid_data : DataIn;
        w_first_word  = {DW{1'b0}};
        w_first_word[lane_of(0)*8 +: 8] = w_carry_valid ? w_carry_byte : 8'h00;
    end

    // FILL/WRITE control, word assembly, skid buffer and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_FILL;
            r_asm        <= {DW{1'b0}};
            r_cnt        <= {CW{1'b0}};
            r_hold       <= {HW{1'b0}};
            r_skid_valid <= 1'b0;
            r_skid_data  <= 8'h00;
            DataOut      <= {DW{1'b0}};
            Address      <= BASE_ADDR;
            WriteEn      <= 1'b0;
            ByteMask     <= {BYTES_PER_WORD{1'b0}};
            Busy         <= 1'b0;
            Overrun      <= 1'b0;
            WordCount    <= 16'd0;
        end else begin
            case (r_state)
                S_FILL: begin
                    r_asm <= w_asm_next;
                    r_cnt <= w_cnt_after;
                    if (w_commit) begin
                        DataOut  <= w_asm_next;
                        ByteMask <= lanes_filled(w_cnt_after);
                        WriteEn  <= 1'b1;
                        Busy     <= 1'b1;
                        r_hold   <= {HW{1'b0}};
                        r_state  <= S_WRITE;
                    end else begin
                        r_state  <= S_FILL;
                    end
                end
                S_WRITE: begin
                    if (Ready && r_skid_valid) begin
                        Overrun <= 1'b1;
                    end else begin
                        Overrun <= Overrun;
                    end
                    if (w_hold_done) begin
                        WriteEn      <= 1'b0;
                        Busy         <= 1'b0;
                        r_state      <= S_FILL;
                        Address      <= Address + ADDR_STEP;
                        WordCount    <= WordCount + 16'd1;
                        r_asm        <= w_first_word;
                        r_cnt        <= w_carry_valid ? CW'(1) : {CW{1'b0}};
                        r_skid_valid <= 1'b0;
                        r_hold       <= {HW{1'b0}};
                    end else begin
                        r_hold <= r_hold + HW'(1);
                        if (Ready && !r_skid_valid) begin
                            r_skid_data  <= DataIn;
                            r_skid_valid <= 1'b1;
                        end else begin
                            r_skid_valid <= r_skid_valid;
                        end
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_word_loader.sv
// Bench for byte_word_loader: two instances (defaults, and big-endian with a
// narrow wrapping address and single-cycle hold) share one stimulus stream.
// A byte-list reference model pushes expected words into per-instance queues;
// a negedge monitor pops and compares whenever WriteEn rises.
module tb_byte_word_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       Ready;
    logic       Flush;
    logic [7:0] DataIn;

    logic [31:0] d0_data;  logic [31:0] d0_addr; logic d0_we; logic [3:0] d0_mask;
    logic        d0_busy;  logic d0_ovr;  logic [15:0] d0_wc;
    logic [31:0] d1_data;  logic [3:0]  d1_addr; logic d1_we; logic [3:0] d1_mask;
    logic        d1_busy;  logic d1_ovr;  logic [15:0] d1_wc;

    byte_word_loader u_dut0 (
        .clk(clk), .reset(reset), .DataIn(DataIn), .Ready(Ready), .Flush(Flush),
        .DataOut(d0_data), .Address(d0_addr), .WriteEn(d0_we), .ByteMask(d0_mask),
        .Busy(d0_busy), .Overrun(d0_ovr), .WordCount(d0_wc)
    );

    byte_word_loader #(
        .BYTES_PER_WORD(4), .ADDR_WIDTH(4), .BASE_ADDR(4'd8),
        .WRITE_HOLD(1), .BIG_ENDIAN(1)
    ) u_dut1 (
        .clk(clk), .reset(reset), .DataIn(DataIn), .Ready(Ready), .Flush(Flush),
        .DataOut(d1_data), .Address(d1_addr), .WriteEn(d1_we), .ByteMask(d1_mask),
        .Busy(d1_busy), .Overrun(d1_ovr), .WordCount(d1_wc)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  mask;
        logic [31:0] addr;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model: bytes collected for the current word, a pending byte
    // received while writing, and the remaining write cycles.
    logic [7:0]  m_buf [2][4];
    int          m_n    [2];
    int          m_busy [2];
    bit          m_pv   [2];
    logic [7:0]  m_pd   [2];
    logic [31:0] m_addr [2];
    logic [15:0] m_wc   [2];
    bit          m_ovr  [2];

    bit   mon_prev [2];
    int   mon_hi   [2];
    exp_t mon_cur  [2];

    function automatic int hold_of(input int i);
        return (i == 0) ? 16 : 1;
    endfunction
    function automatic bit be_of(input int i);
        return (i == 0) ? 1'b0 : 1'b1;
    endfunction
    function automatic logic [31:0] amask_of(input int i);
        return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_000F;
    endfunction
    function automatic logic [31:0] base_of(input int i);
        return (i == 0) ? 32'd0 : 32'd8;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_n[i] = 0; m_busy[i] = 0; m_pv[i] = 1'b0; m_pd[i] = 8'h00;
            m_addr[i] = base_of(i); m_wc[i] = 16'd0; m_ovr[i] = 1'b0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic model_commit(input int i);
        exp_t e;
        int   lane;
        e.data = 32'd0;
        e.mask = 4'd0;
        e.addr = m_addr[i];
        for (int k = 0; k < m_n[i]; k++) begin
            lane = be_of(i) ? 3 - k : k;
            e.data[lane*8 +: 8] = m_buf[i][k];
            e.mask[lane] = 1'b1;
        end
        if (i == 0) q0.push_back(e); else q1.push_back(e);
        m_busy[i] = hold_of(i);
        m_n[i] = 0;
    endtask

    task automatic model_step(input bit r, input bit f, input logic [7:0] d);
        for (int i = 0; i < 2; i++) begin
            if (m_busy[i] > 0) begin
                if (r) begin
                    if (m_pv[i]) m_ovr[i] = 1'b1;
                    else begin m_pd[i] = d; m_pv[i] = 1'b1; end
                end
                m_busy[i]--;
                if (m_busy[i] == 0) begin
                    m_addr[i] = (m_addr[i] + 32'd4) & amask_of(i);
                    m_wc[i]   = m_wc[i] + 16'd1;
                    m_n[i]    = 0;
                    if (m_pv[i]) begin
                        m_buf[i][0] = m_pd[i];
                        m_n[i] = 1;
                        m_pv[i] = 1'b0;
                    end
                end
            end else begin
                if (r) begin
                    m_buf[i][m_n[i]] = d;
                    m_n[i]++;
                end
                if (m_n[i] == 4 || (f && m_n[i] > 0)) model_commit(i);
            end
        end
    endtask

    task automatic mon(input int i, input logic we, input logic bsy, input logic ovr,
                       input logic [15:0] wc, input logic [31:0] dout,
                       input logic [3:0] mk, input logic [31:0] adr);
        chk($sformatf("u%0d busy", i), bsy, m_busy[i] > 0);
        chk($sformatf("u%0d overrun", i), ovr, m_ovr[i]);
        chk($sformatf("u%0d wordcount", i), wc, m_wc[i]);
        if (we && !mon_prev[i]) begin
            if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                chk($sformatf("u%0d unexpected write", i), 1'b1, 1'b0);
                mon_cur[i] = '0;
            end else begin
                mon_cur[i] = (i == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("u%0d data", i), dout, mon_cur[i].data);
                chk($sformatf("u%0d mask", i), mk, mon_cur[i].mask);
                chk($sformatf("u%0d addr", i), adr, mon_cur[i].addr);
            end
            mon_hi[i] = 1;
        end else if (we) begin
            mon_hi[i]++;
        end else if (mon_prev[i]) begin
            chk($sformatf("u%0d hold cycles", i), mon_hi[i], hold_of(i));
            chk($sformatf("u%0d data kept", i), dout, mon_cur[i].data);
            chk($sformatf("u%0d mask kept", i), mk, mon_cur[i].mask);
        end
        mon_prev[i] = we;
    endtask

    // Monitor: compares DUT outputs with the model away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            mon_prev[0] = 1'b0; mon_prev[1] = 1'b0;
            mon_hi[0] = 0; mon_hi[1] = 0;
        end else begin
            mon(0, d0_we, d0_busy, d0_ovr, d0_wc, d0_data, d0_mask, d0_addr);
            mon(1, d1_we, d1_busy, d1_ovr, d1_wc, d1_data, d1_mask, {28'd0, d1_addr});
        end
    end

    task automatic cycle(input bit r, input bit f, input logic [7:0] d);
        #1;
        Ready = r; Flush = f; DataIn = d;
        @(posedge clk);
        model_step(r, f, d);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        cycle(1'b1, 1'b0, a); cycle(1'b1, 1'b0, b);
        cycle(1'b1, 1'b0, c); cycle(1'b1, 1'b0, d);
    endtask

    task automatic chk_reset_values();
        chk("rst d0 we", d0_we, 1'b0);     chk("rst d1 we", d1_we, 1'b0);
        chk("rst d0 data", d0_data, 32'd0); chk("rst d1 data", d1_data, 32'd0);
        chk("rst d0 addr", d0_addr, 32'd0); chk("rst d1 addr", d1_addr, 4'd8);
        chk("rst d0 mask", d0_mask, 4'd0);  chk("rst d1 mask", d1_mask, 4'd0);
        chk("rst d0 busy", d0_busy, 1'b0);  chk("rst d0 ovr", d0_ovr, 1'b0);
        chk("rst d0 wc", d0_wc, 16'd0);     chk("rst d1 wc", d1_wc, 16'd0);
    endtask

    initial begin
        reset = 1'b1; Ready = 1'b0; Flush = 1'b0; DataIn = 8'h00;
        mon_prev[0] = 1'b0; mon_prev[1] = 1'b0;
        model_reset();
        #1;
        chk_reset_values();
        @(posedge clk);
        #2 reset = 1'b0;

        // Full word, both byte orders.
        send4(8'h11, 8'h22, 8'h33, 8'h44);
        #1;
        chk("w0 d0 we", d0_we, 1'b1);
        chk("w0 d0 data", d0_data, 32'h4433_2211);
        chk("w0 d0 mask", d0_mask, 4'b1111);
        chk("w0 d0 addr", d0_addr, 32'd0);
        chk("w0 d1 data", d1_data, 32'h1122_3344);
        chk("w0 d1 addr", d1_addr, 4'd8);
        idle(20);
        chk("w0 d0 next addr", d0_addr, 32'd4);
        chk("w0 d0 wc", d0_wc, 16'd1);

        send4(8'h55, 8'h66, 8'h77, 8'h88);
        #1;
        chk("w1 d1 data", d1_data, 32'h5566_7788);
        chk("w1 d1 addr", d1_addr, 4'd12);
        chk("w1 d0 addr", d0_addr, 32'd4);
        idle(20);
        chk("w1 d1 wc", d1_wc, 16'd2);

        // Partial word flushed on its own.
        cycle(1'b1, 1'b0, 8'hAA); cycle(1'b1, 1'b0, 8'hBB); cycle(1'b0, 1'b1, 8'h00);
        #1;
        chk("flush d0 data", d0_data, 32'h0000_BBAA);
        chk("flush d0 mask", d0_mask, 4'b0011);
        chk("flush d1 data", d1_data, 32'hAABB_0000);
        chk("flush d1 mask", d1_mask, 4'b1100);
        idle(20);

        // Flush with nothing collected.
        cycle(1'b0, 1'b1, 8'h00);
        #1;
        chk("empty flush d0 we", d0_we, 1'b0);
        chk("empty flush d1 we", d1_we, 1'b0);
        idle(2);

        // Skid buffer and overrun.
        send4(8'h01, 8'h02, 8'h03, 8'h04);
        cycle(1'b1, 1'b0, 8'hCC);
        #1 chk("skid d0 ovr", d0_ovr, 1'b0);
        idle(3);
        cycle(1'b1, 1'b0, 8'hDD);
        #1 chk("drop d0 ovr", d0_ovr, 1'b1);
        idle(20);
        chk("sticky d0 ovr", d0_ovr, 1'b1);
        cycle(1'b0, 1'b1, 8'h00);
        #1;
        chk("skid d0 data", d0_data, 32'h0000_00CC);
        chk("skid d0 mask", d0_mask, 4'b0001);
        chk("skid d1 data", d1_data, 32'hCCDD_0000);
        chk("skid d1 ovr", d1_ovr, 1'b0);
        idle(20);

        // Reset asserted between edges in the middle of a hold.
        send4(8'h10, 8'h20, 8'h30, 8'h40);
        idle(5);
        #3 reset = 1'b1;
        #1 chk_reset_values();
        model_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        send4(8'h9A, 8'hBC, 8'hDE, 8'hF0);
        #1;
        chk("post rst d0 we", d0_we, 1'b1);
        chk("post rst d0 addr", d0_addr, 32'd0);
        chk("post rst d1 addr", d1_addr, 4'd8);
        idle(20);

        // Random traffic.
        for (int j = 0; j < 3000; j++) begin
            cycle($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 5, 8'($urandom));
        end
        idle(40);
        chk("q0 drained", q0.size(), 0);
        chk("q1 drained", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
